// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants and helpers for the pipelined adder.
//   EXT_W    : operand-MSB bits carried alongside the data (2 with
//              PIPE_ADDER_OVF_EN defined, 0 otherwise).
//   chunk_w  : bits added per pipeline stage (WIDTH / STAGES).
//   split_ok : true when WIDTH divides evenly into STAGES slices.
package pipe_adder_pkg;

`ifdef PIPE_ADDER_OVF_EN
  localparam int EXT_W = 2;
`else
  localparam int EXT_W = 0;
`endif

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages > 0) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// adder_stage: one pipeline slice of the ripple adder.
//   Adds the low CHUNK bits of the incoming a/b fields plus cin with a chain
//   of full-adder cells, then registers the sum chunk, carry and valid when
//   en is high (en low holds the register).
//   d_in layout, LSB first : [a_rem (RI) | b_rem (RI) | rest (REST)]
//   d    layout, LSB first : [a_rem (RI-CHUNK) | b_rem (RI-CHUNK) | rest | sum chunk]
//   "rest" is the operand-MSB side band followed by the already-computed
//   lower sum bits, so the finished sum grows upward from the top of rest.
// Ports:
//   clk, rst   clock, async active-high reset
//   en         load enable (hold when low)
//   vld_in     valid from upstream
//   cin        carry into this slice
//   d_in       operands still to add plus forwarded bits
//   vld, cout  registered valid and carry out
//   d          registered forwarded bits plus this slice's sum
module adder_stage #(
  parameter int CHUNK = 4,
  parameter int RI    = 8,
  parameter int REST  = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              vld_in,
  input  logic                              cin,
  input  logic [2*RI+REST-1:0]              d_in,
  output logic                              vld,
  output logic                              cout,
  output logic [2*(RI-CHUNK)+REST+CHUNK-1:0] d
);

  localparam int RO  = RI - CHUNK;
  localparam int DOW = 2*RO + REST + CHUNK;

  logic [CHUNK-1:0] s;
  logic             c;
  logic [DOW-1:0]   d_next;

  always_comb begin
    s      = '0;
    c      = cin;
    d_next = '0;
    // full-adder cells, carry rippling LSB to MSB
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = d_in[i] ^ d_in[RI+i] ^ c;
      c    = (d_in[i] & d_in[RI+i]) | (c & (d_in[i] ^ d_in[RI+i]));
    end
    // upper operand bits shift down to become the next slice's low chunk
    for (int i = 0; i < RO; i++) begin
      d_next[i]    = d_in[CHUNK+i];
      d_next[RO+i] = d_in[RI+CHUNK+i];
    end
    for (int i = 0; i < REST; i++)
      d_next[2*RO+i] = d_in[2*RI+i];
    for (int i = 0; i < CHUNK; i++)
      d_next[2*RO+REST+i] = s[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      cout <= 1'b0;
      d    <= '0;
    end else if (en) begin
      vld  <= vld_in;
      cout <= c;
      d    <= d_next;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder, {cout,sum} = a + b + cin.
//   STAGES slices of CHUNK = WIDTH/STAGES bits; carry registered between
//   slices. Valid/ready on both sides, one result per cycle when not
//   stalled. The accepting edge loads slice 0, so the result is presented
//   after STAGES edges counting the accepting one.
//   Optional feature macro: PIPE_ADDER_OVF_EN -- when defined, the operand
//   MSBs ride along the pipeline and ovf reports two's-complement overflow;
//   when undefined, ovf is tied to 0 and no extra flops exist.
// Ports:
//   clk, rst             clock, async active-high reset
//   in_valid, in_ready   input handshake (a, b, cin)
//   out_valid, out_ready output handshake (sum, cout, ovf)
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  import pipe_adder_pkg::*;

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipe_adder: WIDTH must be an exact multiple of STAGES");
  end

  logic [STAGES-1:0]        vld;
  logic [STAGES-1:0]        en;
  logic [STAGES:0]          carry;
  logic [2*WIDTH+EXT_W-1:0] d0;
  logic [WIDTH+EXT_W-1:0]   tail;

`ifdef PIPE_ADDER_OVF_EN
  assign d0 = {b[WIDTH-1], a[WIDTH-1], b, a};
`else
  assign d0 = {b, a};
`endif

  // A slice loads when it is empty or its contents move on this cycle;
  // walking from the output back lets bubbles collapse under a stall.
  always_comb begin
    logic go;
    go      = !vld[LAST] | out_ready;
    en      = '0;
    en[LAST] = go;
    for (int k = LAST - 1; k >= 0; k--) begin
      go    = !vld[k] | go;
      en[k] = go;
    end
  end

  assign in_ready  = en[0];
  assign out_valid = vld[LAST];
  assign carry[0]  = cin;
  assign cout      = carry[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RI   = WIDTH - k*CHUNK;
    localparam int REST = EXT_W + k*CHUNK;
    localparam int DOW  = 2*(RI-CHUNK) + REST + CHUNK;

    logic [2*RI+REST-1:0] d_in;
    logic [DOW-1:0]       d_q;
    logic                 v_in;

    if (k == 0) begin : g_head
      assign d_in = d0;
      assign v_in = in_valid;
    end else begin : g_body
      assign d_in = g_st[k-1].d_q;
      assign v_in = vld[k-1];
    end

    adder_stage #(.CHUNK(CHUNK), .RI(RI), .REST(REST)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (en[k]),
      .vld_in (v_in),
      .cin    (carry[k]),
      .d_in   (d_in),
      .vld    (vld[k]),
      .cout   (carry[k+1]),
      .d      (d_q)
    );
  end

  // last slice holds [a_msb, b_msb (if enabled) | full sum]
  assign tail = g_st[LAST].d_q;
  assign sum  = tail[EXT_W +: WIDTH];

`ifdef PIPE_ADDER_OVF_EN
  assign ovf = (tail[0] == tail[1]) & (sum[WIDTH-1] != tail[0]);
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
module tb_pipe_adder;

`ifdef PIPE_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // three configurations: 4/2 exhaustive, 8/2 directed, 16/4 random
  logic       v4 = 0, or4 = 1, ci4 = 0, r4, ov4, co4, of4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  logic       v8 = 0, or8 = 1, ci8 = 0, r8, ov8, co8, of8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic        v16 = 0, or16 = 1, ci16 = 0, r16, ov16, co16, of16;
  logic [15:0] a16 = 0, b16 = 0, s16;

  pipe_adder #(.WIDTH(4), .STAGES(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4), .cin(ci4),
    .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4));
  pipe_adder #(.WIDTH(8), .STAGES(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8));
  pipe_adder #(.WIDTH(16), .STAGES(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16), .cin(ci16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {ovf, cout, 16-bit sum}
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    longint one = 1, ua = longint'(a), ub = longint'(b), cc = longint'(c);
    longint full = one << w, half = one << (w - 1);
    longint tot = ua + ub + cc;
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb = (ub >= half) ? ub - full : ub;
    longint st = sa + sb + cc;
    logic o = OVF_ON && ((st >= half) || (st < -half));
    return {o, (tot >= full), 16'(tot % full)};
  endfunction

  // scoreboards: expected results queued on input transfer, popped on output transfer
  logic [17:0] q4[$], q8[$], q16[$];
  int out4_cnt = 0;
  logic hold16 = 1'b0;
  logic [16:0] held16 = '0;

  always @(negedge clk) begin
    if (rst) q4.delete();
    else begin
      if (ov4 && or4) begin
        chk("u4_expected_present", longint'(q4.size() != 0), 1);
        if (q4.size() != 0) chk("u4_result", {of4, co4, 12'b0, s4}, q4.pop_front());
        out4_cnt <= out4_cnt + 1;
      end
      if (v4 && r4) q4.push_back(ref_add(4, {12'b0, a4}, {12'b0, b4}, ci4));
    end
  end

  always @(negedge clk) begin
    if (rst) q8.delete();
    else begin
      if (ov8 && or8) begin
        chk("u8_expected_present", longint'(q8.size() != 0), 1);
        if (q8.size() != 0) chk("u8_result", {of8, co8, 8'b0, s8}, q8.pop_front());
      end
      if (v8 && r8) q8.push_back(ref_add(8, {8'b0, a8}, {8'b0, b8}, ci8));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      hold16 <= 1'b0;
    end else begin
      if (hold16) begin
        chk("u16_stall_valid", ov16, 1);
        chk("u16_stall_data", {co16, s16}, held16);
      end
      hold16 <= ov16 && !or16;
      held16 <= {co16, s16};
      if (ov16 && or16) begin
        chk("u16_expected_present", longint'(q16.size() != 0), 1);
        if (q16.size() != 0) chk("u16_result", {of16, co16, s16}, q16.pop_front());
      end
      if (v16 && r16) q16.push_back(ref_add(16, a16, b16, ci16));
    end
  end

  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [7:0] got[$];
    logic [7:0] bp_exp[3];
    int acc, cyc;
    logic took;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[9] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    // reset state
    #1;
    chk("rst_out_valid8", ov8, 0);
    chk("rst_sum8", s8, 0);
    chk("rst_cout8", co8, 0);
    chk("rst_ovf8", of8, 0);
    chk("rst_out_valid16", ov16, 0);
    chk("rst_sum16", s16, 0);
    chk("rst_out_valid4", ov4, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready8", r8, 1);
    chk("rst_in_ready16", r16, 1);

    // exhaustive 4-bit sweep, streamed back to back
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      {a4, b4, ci4} = 9'(i);
      v4 = 1'b1;
      chk("u4_in_ready", r4, 1);
    end
    @(posedge clk); #1 v4 = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("u4_result_count", out4_cnt, 512);

    // directed 8-bit vectors: latency and values
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a8 = tbl[i].a; b8 = tbl[i].b; ci8 = tbl[i].ci; v8 = 1'b1;
      chk("tbl_in_ready", r8, 1);
      @(posedge clk); #1;
      v8 = 1'b0;
      chk("tbl_not_yet_valid", ov8, 0);
      @(posedge clk); #1;
      chk("tbl_out_valid", ov8, 1);
      chk("tbl_sum", s8, tbl[i].s);
      chk("tbl_cout", co8, tbl[i].co);
      chk("tbl_ovf", of8, OVF_ON ? tbl[i].ov : 1'b0);
    end
    @(posedge clk);

    // backpressure: two fill the pipe, third waits; stall 4 cycles
    bp_exp[0] = 8'h11; bp_exp[1] = 8'h22; bp_exp[2] = 8'h33;
    @(posedge clk); #1;
    or8 = 1'b0; v8 = 1'b1; a8 = 8'h10; b8 = 8'h01; ci8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'h20; b8 = 8'h02;
    @(posedge clk); #1;
    a8 = 8'h30; b8 = 8'h03;
    chk("bp_full_in_ready", r8, 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_stall_in_ready", r8, 0);
      chk("bp_stall_valid", ov8, 1);
      chk("bp_stall_sum", s8, 8'h11);
    end
    or8 = 1'b1;
    for (int c = 0; c < 12 && got.size() < 3; c++) begin
      @(negedge clk);
      if (ov8) got.push_back(s8);
      took = v8 && r8;
      @(posedge clk); #1;
      if (took) v8 = 1'b0;
    end
    v8 = 1'b0;
    chk("bp_result_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("bp_order", got[i], bp_exp[i]);

    // reset while two results are in flight (16/4, before any out_valid)
    @(posedge clk); #1;
    v16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; ci16 = 1'b0; or16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'h0001;
    @(posedge clk); #1;
    v16 = 1'b0;
    chk("mid_rst_pre_valid", ov16, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ov16, 0);
    chk("mid_rst_sum", s16, 0);
    chk("mid_rst_cout", co16, 0);
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_rst_in_ready", r16, 1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("mid_rst_no_stale", ov16, 0);
    end

    // random traffic on 16/4 against the scoreboard
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      v16  = ($urandom_range(0, 3) != 0);
      or16 = ($urandom_range(0, 3) != 0);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      ci16 = 1'($urandom);
      @(negedge clk);
      if (v16 && r16) acc++;
      cyc++;
    end
    @(posedge clk); #1;
    v16 = 1'b0; or16 = 1'b1;
    chk("rand_accepts", acc, 10000);
    repeat (8) @(posedge clk);
    #1 chk("rand_drained", q16.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
